// File: rtl/pkg_uart_arb.sv
// Shared types and default constants for the UART transmit arbiter.
package pkg_uart_arb;

    localparam int DEF_AXI_DATA_WIDTH = 8;
    localparam int DEF_NUM_SRC        = 4;
    localparam int DEF_BURST_LEN      = 4;

    // IDLE: no requester owns the output; GRANT: grant is held on index g.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first set bit of req at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                idx = IW'((int'(ptr) + i) % N);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin AXI-Stream arbiter feeding a UART transmitter with a
// registered output stage. Optional burst mode: define UART_ARB_BURST_EN.
module uart_tx_arbiter
    import pkg_uart_arb::*;
#(
    parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
    parameter int NUM_SRC        = DEF_NUM_SRC,
    parameter int BURST_LEN      = DEF_BURST_LEN
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]                s_tvalid,
    output logic [NUM_SRC-1:0]                s_tready,
    output logic [AXI_DATA_WIDTH-1:0]         m_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [$clog2(NUM_SRC)-1:0]        m_tid
);

    localparam int IW = $clog2(NUM_SRC);

    arb_state_e                state_q, state_d;
    logic [IW-1:0]             g_q, g_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [AXI_DATA_WIDTH-1:0] m_tdata_q;
    logic [IW-1:0]             m_tid_q;
    logic                      m_tvalid_q;

    logic [IW-1:0]             pick_idx;
    logic                      pick_any;
    logic                      out_free;
    logic                      accept;
    logic                      keep;
    logic [IW-1:0]             sel;
    logic [NUM_SRC-1:0]        rdy_raw;

`ifdef UART_ARB_BURST_EN
    logic [4:0]                cnt_q, cnt_d;
`endif

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(NUM_SRC - 1)) ? '0 : x + IW'(1);
    endfunction

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req (s_tvalid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign out_free = ~m_tvalid_q | m_tready;

    // Next-state, grant and beat-accept decision for the current cycle.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        rdy_raw  = '0;
        accept   = 1'b0;
        keep     = 1'b0;
        sel      = g_q;
`ifdef UART_ARB_BURST_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (out_free && pick_any) begin
                    sel    = pick_idx;
                    g_d    = pick_idx;
                    accept = 1'b1;
                end
            end
            GRANT: begin
                if (!s_tvalid[g_q]) begin
                    // Requester withdrew valid: drop the grant, move past it.
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(g_q);
`ifdef UART_ARB_BURST_EN
                    cnt_d    = '0;
`endif
                end else if (out_free) begin
                    accept = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            rdy_raw[sel] = 1'b1;
`ifdef UART_ARB_BURST_EN
            cnt_d = (state_q == IDLE) ? 5'd1 : cnt_q + 5'd1;
            keep  = (cnt_d < 5'(BURST_LEN));
            if (!keep) begin
                cnt_d    = '0;
                rr_ptr_d = wrap_inc(sel);
            end
`else
            rr_ptr_d = wrap_inc(sel);
`endif
            state_d = keep ? GRANT : IDLE;
        end
    end

    // Reset also masks the combinational ready so nothing is handshaken
    // while aresetn is low.
    assign s_tready = rdy_raw & {NUM_SRC{aresetn}};

    // State, pointer and registered output beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            g_q        <= '0;
            rr_ptr_q   <= '0;
            m_tdata_q  <= '0;
            m_tid_q    <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                m_tdata_q  <= s_tdata[int'(sel)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                m_tid_q    <= sel;
                m_tvalid_q <= 1'b1;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

`ifdef UART_ARB_BURST_EN
    // Beats delivered within the current grant.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign m_tdata  = m_tdata_q;
    assign m_tid    = m_tid_q;
    assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (default parameters).
module tb_uart_tx_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [1:0]  m_tid;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(
        .AXI_DATA_WIDTH (8),
        .NUM_SRC        (4),
        .BURST_LEN      (4)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tid    (m_tid)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        rdy;
        logic [3:0]  exp_rdy;
        logic        exp_mv;
        logic [7:0]  exp_md;
        logic [1:0]  exp_tid;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] v, input logic [31:0] d, input logic r,
                                input logic [3:0] er, input logic emv, input logic [7:0] emd,
                                input logic [1:0] et);
        vec_t x;
        x.vld = v; x.dat = d; x.rdy = r; x.exp_rdy = er;
        x.exp_mv = emv; x.exp_md = emd; x.exp_tid = et;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn  = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
        chk("rst_m_tdata", 32'(m_tdata), 32'h0);
        chk("rst_m_tid", 32'(m_tid), 32'h0);
        chk("rst_s_tready", 32'(s_tready), 32'h0);
        aresetn = 1'b1;
    endtask

    localparam logic [31:0] D  = 32'h4433_2211;
    localparam logic [31:0] D2 = 32'h4433_223C;

    logic [7:0] seq_in  [4];
    logic [7:0] seq_out [4];
    int         sent    [4];
    int         rcvd    [4];
    logic [3:0] vld_r;
    int         viol;

    initial begin
        aresetn  = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b0;

        // Single source, one beat through the output register.
        do_reset();
        s_tvalid = 4'b0001;
        s_tdata  = 32'h0000_00A5;
        m_tready = 1'b1;
        #1 chk("single_s_tready", 32'(s_tready), 32'h1);
        @(posedge aclk); #1;
        chk("single_m_tvalid", 32'(m_tvalid), 32'h1);
        chk("single_m_tdata", 32'(m_tdata), 32'hA5);
        chk("single_m_tid", 32'(m_tid), 32'h0);

`ifndef UART_ARB_BURST_EN
        // Round robin, backpressure, toggling ready, idle output.
        add(4'b1111, D,  1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add(4'b1111, D,  1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        add(4'b1111, D,  1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
        add(4'b1111, D,  1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        add(4'b1111, D2, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0);
        for (int i = 0; i < 10; i++)
            add(4'b1111, D, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0);
        add(4'b1111, D,  1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        add(4'b0100, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
        add(4'b0100, D,  1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
        add(4'b0001, D,  1'b0, 4'b0000, 1'b1, 8'h33, 2'd2);
        add(4'b0001, D,  1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add(4'b0000, D,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
        add(4'b0000, D,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        add(4'b1000, D,  1'b0, 4'b1000, 1'b1, 8'h44, 2'd3);
        add(4'b1000, D,  1'b0, 4'b0000, 1'b1, 8'h44, 2'd3);
        add(4'b1001, D,  1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);

        do_reset();
        foreach (vecs[k]) begin
            @(negedge aclk);
            s_tvalid = vecs[k].vld;
            s_tdata  = vecs[k].dat;
            m_tready = vecs[k].rdy;
            #1 chk($sformatf("vec%0d_s_tready", k), 32'(s_tready), 32'(vecs[k].exp_rdy));
            @(posedge aclk); #1;
            chk($sformatf("vec%0d_m_tvalid", k), 32'(m_tvalid), 32'(vecs[k].exp_mv));
            if (vecs[k].exp_mv) begin
                chk($sformatf("vec%0d_m_tdata", k), 32'(m_tdata), 32'(vecs[k].exp_md));
                chk($sformatf("vec%0d_m_tid", k), 32'(m_tid), 32'(vecs[k].exp_tid));
            end
        end
`else
        // Burst mode: sources 0 and 2 always valid.
        begin
            logic [1:0] exp_b [9];
            exp_b = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
            do_reset();
            for (int k = 0; k < 9; k++) begin
                @(negedge aclk);
                s_tvalid = 4'b0101;
                s_tdata  = D;
                m_tready = 1'b1;
                @(posedge aclk); #1;
                chk($sformatf("burst%0d_m_tid", k), 32'(m_tid), 32'(exp_b[k]));
                chk($sformatf("burst%0d_m_tvalid", k), 32'(m_tvalid), 32'h1);
            end
        end
`endif

        // Reset in the middle of a held beat.
        do_reset();
        @(negedge aclk);
        s_tvalid = 4'b0100;
        s_tdata  = D;
        m_tready = 1'b0;
        @(negedge aclk);
        s_tvalid = 4'b0000;
        chk("mid_pre_m_tvalid", 32'(m_tvalid), 32'h1);
        #2 aresetn = 1'b0;
        s_tvalid = 4'b1010;
        #1;
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 32'h0);
        chk("mid_rst_m_tdata", 32'(m_tdata), 32'h0);
        chk("mid_rst_m_tid", 32'(m_tid), 32'h0);
        chk("mid_rst_s_tready", 32'(s_tready), 32'h0);
        repeat (2) @(negedge aclk);
        aresetn  = 1'b1;
        m_tready = 1'b1;
        #1 chk("post_rst_s_tready", 32'(s_tready), 32'h2);
        @(posedge aclk); #1;
        chk("post_rst_m_tid", 32'(m_tid), 32'h1);
        chk("post_rst_m_tdata", 32'(m_tdata), 32'h22);

        // Random traffic against a per-source sequence scoreboard.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq_in[i] = 8'(i * 64); seq_out[i] = 8'(i * 64); sent[i] = 0; rcvd[i] = 0;
        end
        vld_r = '0;
        viol  = 0;
        for (int c = 0; c < 10040; c++) begin
            @(negedge aclk);
            for (int i = 0; i < 4; i++) begin
                if (!vld_r[i] && c < 10000) vld_r[i] = 1'($urandom_range(0, 1));
                s_tdata[i*8 +: 8] = seq_in[i];
            end
            s_tvalid = vld_r;
            m_tready = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if ($countones(s_tready) > 1 || (s_tready != 0 && !(!m_tvalid || m_tready))
                || (s_tready & ~s_tvalid) != 0)
                viol++;
            if (m_tvalid && m_tready) begin
                chk($sformatf("sb_src%0d_byte", m_tid), 32'(m_tdata), 32'(seq_out[m_tid]));
                seq_out[m_tid] = seq_out[m_tid] + 8'd1;
                rcvd[m_tid]++;
            end
            for (int i = 0; i < 4; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    seq_in[i] = seq_in[i] + 8'd1;
                    sent[i]++;
                    vld_r[i] = 1'b0;
                end
            end
        end
        chk("sb_ready_violations", 32'(viol), 32'h0);
        chk("sb_pending_after_drain", 32'(vld_r), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb_src%0d_count", i), 32'(rcvd[i]), 32'(sent[i]));
            chk($sformatf("sb_src%0d_active", i), 32'(sent[i] > 100), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
